ahb_matrix_out_arbiter: RTL
===========================

AHB_MATRIX_OUT_ARBITER -- requirements
Module: ahb_matrix_out_arbiter

Interface
REQ-001 SHALL have port HCLK, input, 1 bit: AHB system clock; all state updates on the rising edge.
REQ-002 SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port HREADYM, input, 1 bit: HREADY of the shared output port; high = output transfer completes this cycle.
REQ-004 SHALL have port req_in, input, 3 bits: req_in[n] = input port Sn decoder select for this output AND Sn HTRANS != IDLE.
REQ-005 SHALL have ports trans_in0, trans_in1, trans_in2, input, 2 bits each: HTRANS of input port Sn.
REQ-006 SHALL have port mastlock_in, input, 3 bits: HMASTLOCK of each input port.
REQ-007 SHALL have port addr_in_port, output, 2 bits: registered index of the input port owning the address phase.
REQ-008 SHALL have port no_port, output, 1 bit: registered; high = no input port owns the output (output drives IDLE).
REQ-009 SHALL have port active_out, output, 3 bits: one-hot grant returned to each input-port decoder.
REQ-010 SHALL have port data_in_port, output, 2 bits: registered index of the port owning the data phase.
REQ-011 SHALL have port data_valid, output, 1 bit: registered; high = data phase belongs to a real input port.

Function
REQ-012 SHALL compute next_port and next_none combinationally every cycle from req_in, trans_in*, mastlock_in, addr_in_port, no_port and last_grant.
REQ-013 Hold rule: SHALL keep the current owner when no_port=0 and either its trans_in = SEQ (2'b11) or BUSY (2'b01), or its mastlock_in = 1; the owner is then kept even if req_in of another port is high.
REQ-014 Otherwise SHALL grant round-robin: search ports (last_grant+1) mod 3, (last_grant+2) mod 3, last_grant, and pick the first with req_in = 1.
REQ-015 If no req_in bit is high and the hold rule does not apply, SHALL set next_none = 1, and next_port SHALL equal the current addr_in_port.
REQ-016 SHALL update addr_in_port, no_port and last_grant only on a rising edge with HREADYM = 1; with HREADYM = 0 all arbitration state SHALL be frozen (no re-arbitration mid-wait-state).
REQ-017 last_grant SHALL be loaded with next_port only when next_none = 0; an idle cycle SHALL NOT advance the round-robin pointer.
REQ-018 On a rising edge with HREADYM = 1, data_in_port SHALL load addr_in_port and data_valid SHALL load ~no_port (one-cycle address-to-data pipeline); with HREADYM = 0 both SHALL hold.
REQ-019 active_out[n] SHALL equal (addr_in_port == n) AND ~no_port, registered with no combinational path from req_in.
REQ-020 Grant latency: a request presented with the output idle and HREADYM = 1 SHALL see active_out asserted on the following cycle.
REQ-021 When several ports request at once, exactly one SHALL win per REQ-014; active_out SHALL be one-hot or zero at all times.
REQ-022 addr_in_port SHALL never take value 2'b11; the 2'b11 encoding of next_port SHALL be unreachable.
REQ-023 An owner dropping mastlock_in or its burst (trans_in -> NONSEQ/IDLE) SHALL lose priority at the next HREADYM-qualified edge under normal round-robin.

Reset
REQ-024 On HRESETn low, SHALL asynchronously set addr_in_port = 2'b00, no_port = 1, last_grant = 2 (S0 first priority), data_in_port = 2'b00, data_valid = 0, active_out = 3'b000.
REQ-025 Reset assertion mid-burst or mid-lock SHALL abandon ownership; the first grant after reset SHALL follow REQ-014 from last_grant = 2.

Verification
REQ-026 Reset release, req_in = 3'b111 all NONSEQ, HREADYM = 1 -> grants S0, S1, S2, S0 on successive cycles; active_out = 001, 010, 100, 001.
REQ-027 S1 owns with trans_in1 = SEQ for 4 beats while req_in = 3'b101 -> active_out stays 010 for all 4 beats; the next grant goes to S2.
REQ-028 S0 granted and HREADYM held low 3 cycles while S2 requests -> addr_in_port, active_out, data_in_port unchanged for those 3 cycles; switch to S2 occurs only after HREADYM = 1.
REQ-029 mastlock_in[2] = 1 with trans_in2 = IDLE between locked transfers, req_in = 3'b011 -> S2 retains ownership; on mastlock_in[2] = 0, S0 is granted next.
REQ-030 req_in = 0 for 2 cycles after S1 grant, then req_in = 3'b111 -> no_port = 1, data_valid drops one cycle later; S2 is granted next (pointer not advanced while idle).
REQ-031 HRESETn pulsed low during an S0 SEQ burst -> all outputs at reset values immediately; S0 re-granted first after release.

Source files
------------

// File: rtl/ahb_matrix_out_arbiter.sv
// Output-port arbiter for an AHB matrix: round-robin between three input ports,
// holds the owner through SEQ/BUSY bursts and locked sequences, frozen while HREADYM is low.
module ahb_matrix_out_arbiter (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic [2:0] req_in,
    input  logic [1:0] trans_in0,
    input  logic [1:0] trans_in1,
    input  logic [1:0] trans_in2,
    input  logic [2:0] mastlock_in,
    output logic [1:0] addr_in_port,
    output logic       no_port,
    output logic [2:0] active_out,
    output logic [1:0] data_in_port,
    output logic       data_valid
);

    localparam logic [1:0] TRANS_BUSY = 2'b01;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;

    logic [1:0] addr_q;
    logic       none_q;
    logic [1:0] last_q;
    logic [1:0] last_d;
    logic [1:0] dport_q;
    logic       dvalid_q;

    logic [1:0] next_port;
    logic       next_none;
    logic [1:0] owner_trans;
    logic       owner_lock;
    logic       hold;
    logic [1:0] cand1;
    logic [1:0] cand2;

    function automatic logic [1:0] rr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        owner_trans = 2'b00;
        owner_lock  = 1'b0;
        case (addr_q)
            2'd0: begin owner_trans = trans_in0; owner_lock = mastlock_in[0]; end
            2'd1: begin owner_trans = trans_in1; owner_lock = mastlock_in[1]; end
            2'd2: begin owner_trans = trans_in2; owner_lock = mastlock_in[2]; end
            default: begin owner_trans = 2'b00; owner_lock = 1'b0; end
        endcase
        hold = ~none_q & ((owner_trans == TRANS_SEQ) | (owner_trans == TRANS_BUSY) | owner_lock);
    end

    // Search order: the port after the last winner first, the last winner itself last.
    always_comb begin
        cand1     = rr_inc(last_q);
        cand2     = rr_inc(cand1);
        next_port = addr_q;
        next_none = 1'b0;
        if (hold) begin
            next_port = addr_q;
        end else if (req_in[cand1]) begin
            next_port = cand1;
        end else if (req_in[cand2]) begin
            next_port = cand2;
        end else if (req_in[last_q]) begin
            next_port = last_q;
        end else begin
            next_none = 1'b1;
        end
        last_d = next_none ? last_q : next_port;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q   <= 2'd0;
            none_q   <= 1'b1;
            last_q   <= 2'd2;
            dport_q  <= 2'd0;
            dvalid_q <= 1'b0;
        end else if (HREADYM) begin
            addr_q   <= next_port;
            none_q   <= next_none;
            last_q   <= last_d;
            dport_q  <= addr_q;
            dvalid_q <= ~none_q;
        end
    end

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            active_out[n] = (addr_q == n[1:0]) & ~none_q;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = none_q;
    assign data_in_port = dport_q;
    assign data_valid   = dvalid_q;

endmodule
